branch_hazard_ctrl: RTL and testbench

//   Hazard/branch scheduler for the ID/EX pipeline register. Holds a 2-bit saturating

---
 rtl/branch_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_branch_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_ctrl.sv
// Branch/hazard scheduler for the ID/EX boundary: 2-bit saturating predictor,
// load-use stall, EX-stage misprediction recovery and performance counters.
module branch_hazard_ctrl #(
  parameter int         XLEN      = 32,
  parameter int         CNT_W     = 16,
  parameter logic [1:0] PRED_INIT = 2'b01
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_branch_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_branch_i,
  input  logic             ex_predict_i,
  input  logic             ex_taken_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  ex_pc_target_i,
  output logic             predict_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [1:0]       pred_state_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} pred_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

  pred_t state_q, state_d;
  logic  load_use, mispredict;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= pred_t'(PRED_INIT);
    else       state_q <= state_d;
  end

  // NOTE: state_d defaults to the current state first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (ex_branch_i) begin
      unique case (state_q)
        SNT: state_d = ex_taken_i ? WNT : SNT;
        WNT: state_d = ex_taken_i ? WT  : SNT;
        WT:  state_d = ex_taken_i ? ST  : WNT;
        ST:  state_d = ex_taken_i ? ST  : WT;
        default: state_d = state_q;
      endcase
    end
  end

  // The prediction reflects the registered state only; a same-cycle EX update is not forwarded.
  always_comb begin
    predict_o    = id_branch_i & state_q[1];
    pred_state_o = state_q;
  end

  assign load_use   = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  assign mispredict = ex_branch_i && (ex_predict_i != ex_taken_i);

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    if (rst_i) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (mispredict) begin
      redirect_o    = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      redirect_pc_o = ex_taken_i ? ex_pc_target_i : ex_pc_i + PC_STEP;
    end else if (load_use) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  // Counters saturate rather than wrap so long runs never read as small.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (ex_branch_i && br_cnt_o != CNT_MAX) br_cnt_o <= br_cnt_o + 1'b1;
      if (mispredict && mispred_cnt_o != CNT_MAX) mispred_cnt_o <= mispred_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: a combinational vector table plus
// directed multi-cycle sequences for predictor, counters and reset behaviour.
module tb_branch_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             id_branch_i;
  logic [4:0]       id_rs1_i, id_rs2_i, ex_rd_i;
  logic             ex_memread_i, ex_branch_i, ex_predict_i, ex_taken_i;
  logic [XLEN-1:0]  ex_pc_i, ex_pc_target_i;
  logic             predict_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, redirect_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic [1:0]       pred_state_o;
  logic [CNT_W-1:0] br_cnt_o, mispred_cnt_o;

  int total = 0;
  int bad   = 0;

  branch_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .PRED_INIT(2'b01)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_branch_i(id_branch_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .ex_branch_i(ex_branch_i), .ex_predict_i(ex_predict_i), .ex_taken_i(ex_taken_i),
    .ex_pc_i(ex_pc_i), .ex_pc_target_i(ex_pc_target_i),
    .predict_o(predict_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .pred_state_o(pred_state_o),
    .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        memread;
    logic [4:0]  rd, rs1, rs2;
    logic        branch, pred, taken;
    logic [31:0] pc, target;
    logic [4:0]  exp_ctl;   // {pc_write, ifid_write, ifid_flush, idex_flush, redirect}
    logic [31:0] exp_rpc;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(string name, logic memread, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic branch, logic pred, logic taken,
                              logic [31:0] pc, logic [31:0] target,
                              logic [4:0] exp_ctl, logic [31:0] exp_rpc);
    vec_t v;
    v.name = name; v.memread = memread; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.branch = branch; v.pred = pred; v.taken = taken; v.pc = pc; v.target = target;
    v.exp_ctl = exp_ctl; v.exp_rpc = exp_rpc;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_branch_i = 0; id_rs1_i = 0; id_rs2_i = 0; ex_memread_i = 0; ex_rd_i = 0;
    ex_branch_i = 0; ex_predict_i = 0; ex_taken_i = 0; ex_pc_i = 0; ex_pc_target_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive a resolving branch in EX for one clock edge.
  task automatic branch(logic pred, logic taken, logic [31:0] pc, logic [31:0] target);
    ex_branch_i = 1; ex_predict_i = pred; ex_taken_i = taken;
    ex_pc_i = pc; ex_pc_target_i = target;
    tick();
    idle();
  endtask

  function automatic logic [4:0] ctl();
    return {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, redirect_o};
  endfunction

  initial begin
    idle();
    rst_i = 1;

    // Reset held two cycles, with a taken branch pending that must be discarded.
    tick();
    ex_branch_i = 1; ex_predict_i = 0; ex_taken_i = 1; ex_pc_target_i = 32'h40;
    tick();
    idle();
    id_branch_i = 1;
    #1;
    check("rst_ctl", 32'(ctl()), 32'(5'b00110));
    check("rst_rpc", redirect_pc_o, 32'h0);
    check("rst_state", 32'(pred_state_o), 32'h1);
    check("rst_predict", 32'(predict_o), 32'h0);
    check("rst_br_cnt", 32'(br_cnt_o), 32'h0);
    check("rst_mis_cnt", 32'(mispred_cnt_o), 32'h0);
    rst_i = 0;
    idle();
    tick();

    // Combinational vector table; inputs are idled before each edge so state is untouched.
    vecs[0]  = mk("normal",      0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   5'b11000, 32'h0);
    vecs[1]  = mk("lu_rs1",      1, 5, 5, 0, 0, 0, 0, 32'h0,   32'h0,   5'b00010, 32'h0);
    vecs[2]  = mk("lu_rs2",      1, 5, 3, 5, 0, 0, 0, 32'h0,   32'h0,   5'b00010, 32'h0);
    vecs[3]  = mk("lu_rd0",      1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   5'b11000, 32'h0);
    vecs[4]  = mk("lu_nomatch",  1, 7, 6, 8, 0, 0, 0, 32'h0,   32'h0,   5'b11000, 32'h0);
    vecs[5]  = mk("no_memread",  0, 5, 5, 5, 0, 0, 0, 32'h0,   32'h0,   5'b11000, 32'h0);
    vecs[6]  = mk("br_correct",  0, 0, 0, 0, 1, 1, 1, 32'h200, 32'h300, 5'b11000, 32'h0);
    vecs[7]  = mk("mis_taken",   0, 0, 0, 0, 1, 0, 1, 32'h200, 32'h300, 5'b11111, 32'h300);
    vecs[8]  = mk("mis_ntaken",  0, 0, 0, 0, 1, 1, 0, 32'h200, 32'h300, 5'b11111, 32'h204);
    vecs[9]  = mk("no_branch",   0, 0, 0, 0, 0, 0, 1, 32'h200, 32'h300, 5'b11000, 32'h0);
    vecs[10] = mk("mis_over_lu", 1, 9, 9, 1, 1, 1, 0, 32'h10,  32'h80,  5'b11111, 32'h14);

    foreach (vecs[i]) begin
      ex_memread_i = vecs[i].memread; ex_rd_i = vecs[i].rd;
      id_rs1_i = vecs[i].rs1; id_rs2_i = vecs[i].rs2;
      ex_branch_i = vecs[i].branch; ex_predict_i = vecs[i].pred; ex_taken_i = vecs[i].taken;
      ex_pc_i = vecs[i].pc; ex_pc_target_i = vecs[i].target;
      #1;
      check({vecs[i].name, "_ctl"}, 32'(ctl()), 32'(vecs[i].exp_ctl));
      check({vecs[i].name, "_rpc"}, redirect_pc_o, vecs[i].exp_rpc);
      idle();
      tick();
    end
    check("tbl_state", 32'(pred_state_o), 32'h1);
    check("tbl_br_cnt", 32'(br_cnt_o), 32'h0);

    // Four taken branches from WNT: 10, 11, 11, 11.
    for (int i = 0; i < 4; i++) begin
      branch(1'b1, 1'b1, 32'h100, 32'h180);
      check($sformatf("taken_state%0d", i), 32'(pred_state_o), (i == 0) ? 32'h2 : 32'h3);
    end
    id_branch_i = 1;
    #1;
    check("predict_taken", 32'(predict_o), 32'h1);
    id_branch_i = 0;
    #1;
    check("predict_gated", 32'(predict_o), 32'h0);
    check("br_cnt_4", 32'(br_cnt_o), 32'h4);
    check("mis_cnt_0", 32'(mispred_cnt_o), 32'h0);

    // Predicted taken, actually not taken at 0x100.
    ex_branch_i = 1; ex_predict_i = 1; ex_taken_i = 0; ex_pc_i = 32'h100; ex_pc_target_i = 32'h180;
    #1;
    check("mis100_ctl", 32'(ctl()), 32'(5'b11111));
    check("mis100_rpc", redirect_pc_o, 32'h104);
    tick();
    idle();
    check("mis100_state", 32'(pred_state_o), 32'h2);
    check("mis100_cnt", 32'(mispred_cnt_o), 32'h1);

    // Mispredict (taken to 0x40) coinciding with a load-use hazard.
    ex_memread_i = 1; ex_rd_i = 5; id_rs2_i = 5;
    ex_branch_i = 1; ex_predict_i = 0; ex_taken_i = 1; ex_pc_i = 32'h20; ex_pc_target_i = 32'h40;
    #1;
    check("mislu_ctl", 32'(ctl()), 32'(5'b11111));
    check("mislu_rpc", redirect_pc_o, 32'h40);
    tick();
    idle();
    check("mislu_state", 32'(pred_state_o), 32'h3);

    // Predictor updates even during a load-use stall.
    ex_memread_i = 1; ex_rd_i = 3; id_rs1_i = 3;
    ex_branch_i = 1; ex_predict_i = 0; ex_taken_i = 0;
    #1;
    check("stall_ctl", 32'(ctl()), 32'(5'b00010));
    tick();
    idle();
    check("stall_state", 32'(pred_state_o), 32'h2);
    check("br_cnt_7", 32'(br_cnt_o), 32'h7);

    // Twenty more branches saturate the 4-bit branch counter.
    for (int i = 0; i < 20; i++) branch(1'b0, 1'b0, 32'h300, 32'h0);
    check("br_cnt_sat", 32'(br_cnt_o), 32'hF);
    check("snt_floor", 32'(pred_state_o), 32'h0);

    // PC+4 wraps at the top of the address space.
    ex_branch_i = 1; ex_predict_i = 1; ex_taken_i = 0; ex_pc_i = 32'hFFFF_FFFC;
    #1;
    check("wrap_rpc", redirect_pc_o, 32'h0);
    check("wrap_redirect", 32'(redirect_o), 32'h1);
    tick();
    idle();
    check("mis_cnt_3", 32'(mispred_cnt_o), 32'h3);
    for (int i = 0; i < 20; i++) branch(1'b1, 1'b0, 32'h8, 32'h0);
    check("mis_cnt_sat", 32'(mispred_cnt_o), 32'hF);

    // Reset mid-operation clears everything and discards the concurrent update.
    rst_i = 1;
    ex_branch_i = 1; ex_predict_i = 1; ex_taken_i = 0; ex_pc_i = 32'h500;
    #1;
    check("midrst_ctl", 32'(ctl()), 32'(5'b00110));
    check("midrst_rpc", redirect_pc_o, 32'h0);
    tick();
    rst_i = 0;
    idle();
    #1;
    check("midrst_state", 32'(pred_state_o), 32'h1);
    check("midrst_cnts", {24'h0, br_cnt_o, mispred_cnt_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
